// File: rtl/buffer_interface_pkg.sv
// Shared definitions for buffer_interface: FSM state encoding, ctrl_word
// field offsets, write/read flag bit indices and the default address width.
package buffer_interface_pkg;

  localparam int BUF_SIZE_DEF = 9;   // 512-line buffer

  // ctrl_word field offsets
  localparam int F_FIRST = 0;        // [8:0]   firstline
  localparam int F_LAST  = 9;        // [17:9]  lastline
  localparam int F_STEP  = 18;       // [21:18] step
  localparam int F_READ  = 22;
  localparam int F_WRITE = 23;
  localparam int F_CLEAR = 24;
  localparam int STEP_W  = 4;

  // flag bit indices (wr_flags_i / rd_flags_o)
  localparam int FL_SOP = 0;
  localparam int FL_EOP = 1;
  localparam int FL_ERR = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRE_READ = 3'd1,
    READING  = 3'd2,
    WRITING  = 3'd3,
    DONE     = 3'd4,
    ERROR    = 3'd5
  } state_t;

endpackage

// File: rtl/buffer_interface.sv
// buffer_interface: moves words between a streaming port pair and port B of
// an external synchronous-read RAM (ram_2port).
//   clk, rst            : clock, asynchronous active-high reset
//   ctrl_word, go       : command word and its one-cycle accept strobe
//   done, error         : level status of the last transfer
//   en_o, we_o, addr_o  : RAM port enable / write enable / address
//   dat_to_buf          : RAM write data; dat_from_buf: RAM read data (1 cycle)
//   wr_*                : write stream in (data, flags {err,eop,sop}, write, ready)
//   rd_*                : read stream out (data, flags {0,0,eop,sop}, ready, read)
// Optional: BUFFER_INTERFACE_STEP_EN makes the address advance by the
// command's step field (0 treated as 1) instead of by 1.
module buffer_interface
  import buffer_interface_pkg::*;
#(
  parameter int BUF_SIZE = BUF_SIZE_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         ctrl_word,
  input  logic                go,
  output logic                done,
  output logic                error,
  output logic                en_o,
  output logic                we_o,
  output logic [BUF_SIZE-1:0] addr_o,
  output logic [31:0]         dat_to_buf,
  input  logic [31:0]         dat_from_buf,
  input  logic [31:0]         wr_data_i,
  input  logic [3:0]          wr_flags_i,
  input  logic                wr_write_i,
  output logic                wr_ready_o,
  output logic [31:0]         rd_data_o,
  output logic [3:0]          rd_flags_o,
  output logic                rd_ready_o,
  input  logic                rd_read_i
);

  state_t              state;
  logic [BUF_SIZE-1:0] addr;      // next RAM line to touch
  logic [BUF_SIZE-1:0] cur;       // line currently presented on rd_data_o
  logic [BUF_SIZE-1:0] first_q, last_q;
  logic [BUF_SIZE-1:0] inc;

  logic cmd_clear, cmd_read, cmd_write, accept, abort;
  logic sop, eop, rd_take, wr_take, wr_bad, wr_last;

  assign cmd_clear = ctrl_word[F_CLEAR];
  assign cmd_read  = ctrl_word[F_READ];
  assign cmd_write = ctrl_word[F_WRITE];
  assign abort     = go && cmd_clear;
  assign accept    = go && !cmd_clear && (cmd_read || cmd_write) &&
                     (state == IDLE || state == DONE || state == ERROR);

`ifdef BUFFER_INTERFACE_STEP_EN
  logic [STEP_W-1:0] step_q;
  logic              unused_ctrl;
  assign unused_ctrl = ^ctrl_word[31:25];
  assign inc = (step_q == '0) ? BUF_SIZE'(1) : BUF_SIZE'(step_q);
`else
  logic unused_ctrl;
  assign unused_ctrl = ^{ctrl_word[31:25], ctrl_word[F_STEP +: STEP_W]};
  assign inc = BUF_SIZE'(1);
`endif

  assign sop     = (cur == first_q);
  assign eop     = (cur == last_q);
  assign rd_take = (state == READING) && rd_read_i;
  assign wr_take = (state == WRITING) && wr_write_i;
  // Write-side termination decided on the word being written this cycle.
  assign wr_bad  = wr_flags_i[FL_ERR] || (wr_flags_i[FL_SOP] && wr_flags_i[FL_EOP]);
  assign wr_last = wr_flags_i[FL_EOP] || (addr == last_q);

  // RAM port is driven straight from state + handshake so reads are
  // zero-wait: the fetch issued with rd_read_i lands on dat_from_buf next cycle.
  // A clear in the same cycle suppresses the access so aborted transfers never
  // touch the RAM; the final read (eop consumed) issues no extra fetch.
  always_comb begin
    en_o       = 1'b0;
    we_o       = 1'b0;
    addr_o     = addr;
    dat_to_buf = wr_data_i;
    if (!abort) begin
      en_o = (state == PRE_READ) || (rd_take && !eop) || wr_take;
      we_o = wr_take;
    end
    rd_ready_o = (state == READING);
    wr_ready_o = (state == WRITING);
    rd_data_o  = dat_from_buf;
    rd_flags_o = {2'b00, eop && rd_ready_o, sop && rd_ready_o};
    done       = (state == DONE);
    error      = (state == ERROR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      addr    <= '0;
      cur     <= '0;
      first_q <= '0;
      last_q  <= '0;
`ifdef BUFFER_INTERFACE_STEP_EN
      step_q  <= '0;
`endif
    end else if (abort) begin
      state <= IDLE;
    end else if (accept) begin
      addr    <= ctrl_word[F_FIRST +: BUF_SIZE];
      first_q <= ctrl_word[F_FIRST +: BUF_SIZE];
      last_q  <= ctrl_word[F_LAST  +: BUF_SIZE];
`ifdef BUFFER_INTERFACE_STEP_EN
      step_q  <= ctrl_word[F_STEP +: STEP_W];
`endif
      state   <= cmd_read ? PRE_READ : WRITING;  // read wins if both set
    end else begin
      case (state)
        PRE_READ: begin
          cur   <= addr;
          addr  <= addr + inc;
          state <= READING;
        end
        READING: if (rd_read_i) begin
          if (eop) begin
            state <= DONE;
          end else begin
            cur  <= addr;
            addr <= addr + inc;
          end
        end
        WRITING: if (wr_write_i) begin
          addr <= addr + inc;
          if (wr_bad)       state <= ERROR;
          else if (wr_last) state <= DONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_buffer_interface.sv
// Scoreboarded random bench for buffer_interface with a behavioural RAM on
// the RAM port and an address-level reference image of the buffer.
module tb_buffer_interface;
  import buffer_interface_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ctrl_word = '0;
  logic        go = 1'b0;
  logic        done, error, en_o, we_o;
  logic [8:0]  addr_o;
  logic [31:0] dat_to_buf;
  logic [31:0] dat_from_buf = '0;
  logic [31:0] wr_data_i = '0;
  logic [3:0]  wr_flags_i = '0;
  logic        wr_write_i = 1'b0;
  logic        wr_ready_o;
  logic [31:0] rd_data_o;
  logic [3:0]  rd_flags_o;
  logic        rd_ready_o;
  logic        rd_read_i = 1'b0;

  buffer_interface #(.BUF_SIZE(9)) dut (
    .clk(clk), .rst(rst), .ctrl_word(ctrl_word), .go(go),
    .done(done), .error(error), .en_o(en_o), .we_o(we_o), .addr_o(addr_o),
    .dat_to_buf(dat_to_buf), .dat_from_buf(dat_from_buf),
    .wr_data_i(wr_data_i), .wr_flags_i(wr_flags_i), .wr_write_i(wr_write_i),
    .wr_ready_o(wr_ready_o), .rd_data_o(rd_data_o), .rd_flags_o(rd_flags_o),
    .rd_ready_o(rd_ready_o), .rd_read_i(rd_read_i)
  );

  always #5 clk = ~clk;

  // external RAM, synchronous read on port B
  logic [31:0] ram [512];
  logic [31:0] ref_mem [512];
  always @(posedge clk) begin
    if (en_o) begin
      if (we_o) ram[addr_o] <= dat_to_buf;
      else      dat_from_buf <= ram[addr_o];
    end
  end

  typedef struct { logic [31:0] d; logic [3:0] f; } exp_t;
  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // monitor: every consumed read word is popped and compared
  always @(negedge clk) begin
    if (!rst && rd_ready_o && rd_read_i) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_unexpected actual=%0h expected=none", rd_data_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rd_data", rd_data_o, e.d);
        chk("rd_flags", {28'b0, rd_flags_o}, {28'b0, e.f});
      end
    end
  end

  function automatic logic [31:0] mk(input int f, input int l, input bit rd,
                                     input bit wr, input bit clr);
    return {7'b0, clr, wr, rd, 4'd0, 9'(l), 9'(f)};
  endfunction

  // all tasks start and end at posedge+1
  task automatic issue_go(input logic [31:0] cw);
    ctrl_word = cw;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  // wait_pct<0: fixed two wait cycles per word; stop_after<0: full transfer
  task automatic read_xfer(input int first, input int last, input int wait_pct,
                           input int stop_after);
    int n, limit, consumed, cyc;
    n = ((last - first) & 511) + 1;
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.d = ref_mem[(first + i) % 512];
      e.f = {2'b00, (i == n - 1), (i == 0)};
      exp_q.push_back(e);
    end
    limit = (stop_after < 0) ? n : stop_after;
    issue_go(mk(first, last, 1, 0, 0));
    consumed = 0;
    cyc = 0;
    while (consumed < limit && cyc < 5000) begin
      if (wait_pct < 0) rd_read_i = (cyc % 3 == 2);
      else              rd_read_i = ($urandom_range(99) >= wait_pct);
      @(negedge clk);
      if (rd_ready_o && rd_read_i) consumed++;
      @(posedge clk); #1;
      cyc++;
    end
    rd_read_i = 1'b0;
    if (cyc >= 5000) begin
      checks++; errors++;
      $display("FAIL rd_timeout actual=%0d expected=%0d", consumed, limit);
    end
    if (stop_after < 0) begin
      chk("rd_done", done, 1);
      chk("rd_ready_after", rd_ready_o, 0);
      chk("rd_queue_empty", exp_q.size(), 0);
    end else begin
      chk("partial_done", done, 0);
      issue_go(mk(0, 0, 0, 0, 1));
      chk("clear_done", done, 0);
      chk("clear_idle", {rd_ready_o, wr_ready_o, error}, 0);
      exp_q.delete();
    end
  endtask

  // eop_at: word index carrying eop (-1 none); bad_first: sop&eop on word 0
  task automatic write_xfer(input int first, input int last, input int nw,
                            input logic [31:0] base, input bit rnd,
                            input int eop_at, input bit bad_first);
    int term, i, cyc, mism;
    logic [31:0] d;
    logic [3:0]  f;
    int a;
    issue_go(mk(first, last, 0, 1, 0));
    term = 0; i = 0; cyc = 0;
    while (i < nw && term == 0 && cyc < 5000) begin
      cyc++;
      if ($urandom_range(3) == 0) begin
        wr_write_i = 1'b0;
        @(posedge clk); #1;
        continue;
      end
      d = rnd ? $urandom : base + 32'(i);
      f = '0;
      if (i == eop_at) f[FL_EOP] = 1'b1;
      if (bad_first && i == 0) f = 4'b0011;
      a = (first + i) % 512;
      chk("wr_ready", wr_ready_o, 1);
      wr_write_i = 1'b1; wr_data_i = d; wr_flags_i = f;
      ref_mem[a] = d;
      if (f[FL_ERR] || (f[FL_SOP] && f[FL_EOP])) term = 2;
      else if (f[FL_EOP] || a == last)          term = 1;
      @(posedge clk); #1;
      i++;
    end
    wr_write_i = 1'b0; wr_flags_i = '0;
    chk("wr_done", done, (term == 1));
    chk("wr_error", error, (term == 2));
    chk("wr_ready_end", wr_ready_o, (term == 0));
    mism = 0;
    for (int k = 0; k < 512; k++) if (ram[k] !== ref_mem[k]) mism++;
    chk("ram_image", mism, 0);
  endtask

  initial begin
    for (int k = 0; k < 512; k++) begin
      ram[k] = 32'(k);
      ref_mem[k] = 32'(k);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {done, error, en_o, we_o, rd_ready_o, wr_ready_o}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_outputs", {done, error, rd_ready_o, wr_ready_o}, 0);

    read_xfer(5, 10, 0, -1);
    read_xfer(5, 10, -1, -1);
    read_xfer(5, 10, -1, 3);
    read_xfer(505, 3, 0, -1);
    read_xfer(0, 511, 30, -1);

    write_xfer(10, 15, 6, 72, 0, -1, 0);
    read_xfer(10, 15, 0, -1);
    write_xfer(15, 20, 6, 100, 0, 4, 0);
    chk("ram20_untouched", ram[20], 20);
    write_xfer(55, 200, 3, 300, 0, -1, 1);
    write_xfer(508, 4, 9, 601, 0, -1, 0);
    read_xfer(508, 4, 20, -1);
    read_xfer(7, 7, 0, -1);

    for (int it = 0; it < 8; it++) begin
      int f, len, l;
      f   = $urandom_range(511);
      len = $urandom_range(1, 40);
      l   = (f + len - 1) % 512;
      write_xfer(f, l, len, 0, 1, -1, 0);
      read_xfer(f, l, 40, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
